// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART receive path: receiver
//                state encodings and default frame/oversampling constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default frame geometry
    localparam int c_default_width      = 8;
    localparam int c_default_oversample = 16;

    // Receiver state encodings
    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_START  = 3'b001,
        ST_DATA   = 3'b010,
        ST_PARITY = 3'b011,
        ST_STOP   = 3'b100
    } rx_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sync
//  Description : Two-flop synchronizer for the asynchronous serial line plus
//                falling-edge detect on the synchronized value. All flops
//                reset to 1 so an idle line never looks like a start edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rx_in,
    output logic rx_s,
    output logic fall
);

    logic r_meta_q, w_meta_d;
    logic r_sync_q, w_sync_d;
    logic r_prev_q, w_prev_d;

    // Next-value logic for the synchronizer chain and previous-sample flop
    always_comb begin
        w_meta_d = rx_in;
        w_sync_d = r_meta_q;
        w_prev_d = r_sync_q;
    end

    // Synchronizer and history registers, reset to line-idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta_q <= 1'b1;
            r_sync_q <= 1'b1;
            r_prev_q <= 1'b1;
        end else begin
            r_meta_q <= w_meta_d;
            r_sync_q <= w_sync_d;
            r_prev_q <= w_prev_d;
        end
    end

    assign rx_s = r_sync_q;
    assign fall = r_prev_q & ~r_sync_q;

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : uart_receiver
//  Description : UART receive stage. Oversamples the serial line, validates
//                the start bit, mid-bit samples WIDTH data bits LSB first,
//                checks the stop bit and presents the byte on a valid/ready
//                output register with framing/overrun error pulses.
//                Optional even-parity bit enabled by `UART_RX_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver
    import uart_pkg::*;
#(
    parameter int WIDTH      = c_default_width,
    parameter int OVERSAMPLE = c_default_oversample
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             os_tick,
    input  logic             rx_in,
    input  logic             rx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun_err,
    output logic             parity_err
);

    localparam int c_tick_w = $clog2(OVERSAMPLE);
    localparam int c_bit_w  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(OVERSAMPLE - 1);
    localparam logic [c_tick_w-1:0] c_tick_mid  = c_tick_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(WIDTH - 1);

    logic w_rx_s;
    logic w_fall;

    rx_state_e            r_state_q, w_state_d;
    logic [c_tick_w-1:0]  r_tick_q,  w_tick_d;
    logic [c_bit_w-1:0]   r_bit_q,   w_bit_d;
    logic [WIDTH-1:0]     r_shreg_q, w_shreg_d;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH-1:0]     r_data_q,  w_data_d;
    logic                 r_valid_q, w_valid_d;
    logic                 r_frame_err_q, w_frame_err_d;
    logic                 r_overrun_q,   w_overrun_d;
    logic                 w_load;
    logic                 w_stop_bad;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bad_q,    w_par_bad_d;
    logic                 r_parity_err_q, w_parity_err_d;
`endif

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .rx_in (rx_in),
        .rx_s  (w_rx_s),
        .fall  (w_fall)
    );

    // New sample enters at the MSB so the first received bit ends in the LSB
    assign w_shift = {w_rx_s, r_shreg_q};

    // Frame sequencing: start validation, bit sampling and stop-bit check
    always_comb begin
        w_state_d  = r_state_q;
        w_tick_d   = r_tick_q;
        w_bit_d    = r_bit_q;
        w_shreg_d  = r_shreg_q;
        w_load     = 1'b0;
        w_stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_d = r_par_bad_q;
`endif
        case (r_state_q)
            ST_IDLE: begin
                // Edge-triggered: a line held low cannot re-trigger
                if (w_fall) begin
                    w_tick_d  = '0;
                    w_state_d = ST_START;
                end
            end
            ST_START: begin
                if (os_tick) begin
                    if (r_tick_q == c_tick_mid) begin
                        if (!w_rx_s) begin
                            w_tick_d  = '0;
                            w_bit_d   = '0;
                            w_state_d = ST_DATA;
`ifdef UART_RX_PARITY_EN
                            w_par_bad_d = 1'b0;
`endif
                        end else begin
                            // Line back high at mid start bit: glitch
                            w_state_d = ST_IDLE;
                        end
                    end else begin
                        w_tick_d = r_tick_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (os_tick) begin
                    if (r_tick_q == c_tick_last) begin
                        w_shreg_d = w_shift[WIDTH:1];
                        w_tick_d  = '0;
                        if (r_bit_q == c_bit_last) begin
`ifdef UART_RX_PARITY_EN
                            w_state_d = ST_PARITY;
`else
                            w_state_d = ST_STOP;
`endif
                        end else begin
                            w_bit_d = r_bit_q + 1'b1;
                        end
                    end else begin
                        w_tick_d = r_tick_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (os_tick) begin
                    if (r_tick_q == c_tick_last) begin
                        w_par_bad_d = (^r_shreg_q) ^ w_rx_s;
                        w_tick_d    = '0;
                        w_state_d   = ST_STOP;
                    end else begin
                        w_tick_d = r_tick_q + 1'b1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (os_tick) begin
                    if (r_tick_q == c_tick_last) begin
                        w_tick_d  = '0;
                        w_state_d = ST_IDLE;
                        if (w_rx_s) begin
                            w_load = 1'b1;
                        end else begin
                            w_stop_bad = 1'b1;
                        end
                    end else begin
                        w_tick_d = r_tick_q + 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // Output register handshake and error pulse generation
    always_comb begin
        w_data_d      = r_data_q;
        w_valid_d     = r_valid_q;
        w_overrun_d   = 1'b0;
        w_frame_err_d = w_stop_bad;
`ifdef UART_RX_PARITY_EN
        w_parity_err_d = 1'b0;
`endif
        if (w_load) begin
            // A concurrent consume frees the slot, so only an unconsumed
            // byte being overwritten counts as overrun
            w_data_d    = r_shreg_q;
            w_valid_d   = 1'b1;
            w_overrun_d = r_valid_q & ~rx_ready;
`ifdef UART_RX_PARITY_EN
            w_parity_err_d = r_par_bad_q;
`endif
        end else if (r_valid_q && rx_ready) begin
            w_valid_d = 1'b0;
        end
    end

    // State, counter, shift and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_tick_q      <= '0;
            r_bit_q       <= '0;
            r_shreg_q     <= '0;
            r_data_q      <= '0;
            r_valid_q     <= 1'b0;
            r_frame_err_q <= 1'b0;
            r_overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad_q    <= 1'b0;
            r_parity_err_q <= 1'b0;
`endif
        end else begin
            r_state_q     <= w_state_d;
            r_tick_q      <= w_tick_d;
            r_bit_q       <= w_bit_d;
            r_shreg_q     <= w_shreg_d;
            r_data_q      <= w_data_d;
            r_valid_q     <= w_valid_d;
            r_frame_err_q <= w_frame_err_d;
            r_overrun_q   <= w_overrun_d;
`ifdef UART_RX_PARITY_EN
            r_par_bad_q    <= w_par_bad_d;
            r_parity_err_q <= w_parity_err_d;
`endif
        end
    end

    assign rx_data     = r_data_q;
    assign rx_valid    = r_valid_q;
    assign busy        = (r_state_q != ST_IDLE);
    assign frame_err   = r_frame_err_q;
    assign overrun_err = r_overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = r_parity_err_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule : uart_receiver
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_receiver
//  Description : Scoreboard bench for uart_receiver (os_tick tied high,
//                OVERSAMPLE=16). Parity scenarios build with
//                `UART_RX_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    typedef struct {
        logic [7:0] data;
        logic       frame;
        logic       overrun;
        logic       parity;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       os_tick = 1'b1;
    logic       rx_in = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       frame_err;
    logic       overrun_err;
    logic       parity_err;

    int   checks = 0;
    int   errors = 0;
    int   valid_cycles = 0;
    int   busy_cycles = 0;
    exp_t exp_q[$];
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_receiver #(.WIDTH(8), .OVERSAMPLE(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .os_tick     (os_tick),
        .rx_in       (rx_in),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .busy        (busy),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic fr, input logic ov, input logic pe);
        exp_t e;
        e.data = d; e.frame = fr; e.overrun = ov; e.parity = pe;
        exp_q.push_back(e);
    endtask

    // One bit period of line level, starting at a negedge
    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
        drive_bit(stop_b);
        rx_in = 1'b1;
    endtask

    // Monitor: pops an expectation whenever the DUT reports a load or flag
    task automatic monitor();
        logic prev_v = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rx_valid) valid_cycles++;
            if (busy) busy_cycles++;
            if (frame_err || overrun_err || parity_err || (rx_valid && !prev_v)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {29'd0, frame_err, overrun_err, parity_err}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_err", frame_err, e.frame);
                    check("overrun_err", overrun_err, e.overrun);
                    check("parity_err", parity_err, e.parity);
                    if (!e.frame) begin
                        check("rx_data", rx_data, e.data);
                        check("rx_valid_on_load", rx_valid, 1'b1);
                    end
                end
            end
            prev_v = rx_valid;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (4) @(negedge clk);
        rst = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_errs", {frame_err, overrun_err, parity_err}, 3'b000);
        repeat (5) @(negedge clk);

        // Frame 0xA5, consumer ready: one-cycle valid pulse
        rx_ready = 1'b1;
        valid_cycles = 0;
        push(8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1);
        repeat (20) @(negedge clk);
        check("a5_valid_pulse_len", valid_cycles, 1);
        check("a5_valid_cleared", rx_valid, 1'b0);

        // Five-cycle glitch on idle line
        valid_cycles = 0;
        busy_cycles = 0;
        rx_in = 1'b0;
        repeat (5) @(negedge clk);
        rx_in = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_busy_1to9", (busy_cycles >= 1 && busy_cycles <= 9), 1'b1);
        check("glitch_no_valid", valid_cycles, 0);
        check("glitch_idle", busy, 1'b0);

        // Frame 0x3C with bad stop bit
        valid_cycles = 0;
        push(8'h3C, 1'b1, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0);
        repeat (20) @(negedge clk);
        check("frame_rx_data_kept", rx_data, 8'hA5);
        check("frame_no_valid", valid_cycles, 0);

        // Back-to-back 0x11, 0x22 with consumer stalled
        rx_ready = 1'b0;
        push(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h11, 1'b1);
        push(8'h22, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1);
        repeat (10) @(negedge clk);
        check("overrun_rx_data", rx_data, 8'h22);
        check("overrun_rx_valid", rx_valid, 1'b1);
        rx_ready = 1'b1;
        @(negedge clk);
        check("consume_clears_valid", rx_valid, 1'b0);

        // Reset during data bit 4 of 0xFF, then 0x5A
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midreset_busy", busy, 1'b0);
        check("midreset_valid", rx_valid, 1'b0);
        repeat (40) @(negedge clk);
        push(8'h5A, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1);
        repeat (20) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: even parity bit is 1
        par_flip = 1'b1;
        push(8'h07, 1'b0, 1'b0, 1'b1);
        send_frame(8'h07, 1'b1);
        par_flip = 1'b0;
        push(8'h07, 1'b0, 1'b0, 1'b0);
        send_frame(8'h07, 1'b1);
        repeat (20) @(negedge clk);
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_receiver
`default_nettype wire

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage; the downstream consumer of the UART transmitter's serial line within the APB UART. It oversamples `rx_in` with a 16x baud enable, validates the start bit, and mid-bit samples `WIDTH` data bits LSB first. It checks the stop bit and presents the byte on a valid/ready output register for the APB register file, flagging framing and overrun errors.

## Interface
- `WIDTH`, 8, data bits per frame
- `OVERSAMPLE`, 16, `os_tick` pulses per bit period; even, ≥4
- `clk`  input  1  system clock
- `rst`  input  1  synchronous active-high reset
- `os_tick`  input  1  oversample enable, one `clk` wide; may be tied high
- `rx_in`  input  1  asynchronous serial line, idle high
- `rx_ready`  input  1  consumer accepts `rx_data` this cycle
- `rx_data`  output  WIDTH  last received byte
- `rx_valid`  output  1  `rx_data` holds an unconsumed byte
- `busy`  output  1  frame reception in progress (state ≠ IDLE)
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low
- `overrun_err`  output  1  one-cycle pulse: byte completed while `rx_valid` high and not consumed
- `parity_err`  output  1  one-cycle pulse: parity mismatch (constant 0 without `UART_RX_PARITY_EN`)

## Operation
- `rx_in` passes through a 2-flop synchronizer, reset value 1; `rx_prev` holds the previous synchronized value. All logic uses the synchronized value `rx_s`.
- `tick_cnt` ranges 0..OVERSAMPLE-1 and advances only on `os_tick`. `bit_cnt` ranges 0..WIDTH-1.
- States:
  - IDLE
    - On falling edge (`rx_prev`=1, `rx_s`=0): clear `tick_cnt`, go to START.
    - A line held low (break) never re-triggers.
  - START
    - On `os_tick` with `tick_cnt`==OVERSAMPLE/2-1: if `rx_s`=0, clear `tick_cnt` and `bit_cnt`, go to DATA. Otherwise go to IDLE (glitch rejected, no flag).
  - DATA
    - On `os_tick` with `tick_cnt`==OVERSAMPLE-1: shift `rx_s` into the MSB of `shreg` (right shift, so the first bit ends in the LSB) and clear `tick_cnt`.
    - When `bit_cnt`==WIDTH-1 go to PARITY (macro) or STOP; otherwise increment `bit_cnt`.
  - PARITY (macro only)
    - On `os_tick` with `tick_cnt`==OVERSAMPLE-1: latch `par_bad` = (^`shreg`) ^ `rx_s` (even parity), go to STOP.
  - STOP
    - On `os_tick` with `tick_cnt`==OVERSAMPLE-1, go to IDLE.
    - If `rx_s`=1: load `rx_data`<=`shreg`, set `rx_valid`, pulse `parity_err` if `par_bad`.
    - If `rx_s`=0: pulse `frame_err`; `rx_data` and `rx_valid` unchanged; `parity_err` not reported.
- Output handshake:
  - `rx_valid` clears on a cycle with `rx_valid`&`rx_ready` and no concurrent load.
  - Load while `rx_valid`=1 and `rx_ready`=0: overwrite `rx_data`, keep `rx_valid`=1, pulse `overrun_err`.
  - Load with `rx_valid`=1 and `rx_ready`=1 in the same cycle: old byte consumed, new byte loaded, `rx_valid` stays 1, no overrun.
- `rx_ready` while `rx_valid`=0 is ignored.

## Timing
- Reset (synchronous, `rst`=1 at a `clk` edge):
  - Outputs: `rx_data`=0, `rx_valid`=0, `busy`=0, all error outputs 0.
  - Internal: state IDLE, counters 0, `shreg`=0, synchronizer and `rx_prev`=1.
- Reset mid-frame aborts the frame; no flags are raised.
- Synchronizer latency: 2 `clk`. Start is recognized 1 `clk` after `rx_s` falls.
- Sample points fall at the centre of each bit: OVERSAMPLE/2 ticks into the start bit, then every OVERSAMPLE ticks.
- `rx_valid`, `frame_err`, `parity_err` and `overrun_err` all assert on the `clk` edge following the stop-bit sample `os_tick`.
- `busy` drops in the same cycle that `rx_valid` rises.
- Back-to-back frames: a new start edge is accepted from the first IDLE cycle onward; zero idle bits between frames are supported.
- Without parity, a frame takes 1+WIDTH+1 bit periods.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is present.
  - One even-parity bit is expected between the data bits and the stop bit.
  - `parity_err` is driven.
  - The byte is delivered even when parity mismatches.
- `UART_RX_PARITY_EN` undefined:
  - No PARITY state; STOP directly follows the last data bit.
  - `parity_err` is tied 0.

## Structure
- Shared package `uart_pkg`: state encodings (IDLE=3'b000, START=3'b001, DATA=3'b010, PARITY=3'b011, STOP=3'b100), default `OVERSAMPLE` and `WIDTH` constants.
- Sub-module `uart_rx_sync`: 2-flop synchronizer plus falling-edge detect. Outputs `rx_s` and `fall`; reset value 1.

## Test plan
All scenarios use `os_tick` tied high and `OVERSAMPLE`=16.
- Frame 0xA5 with `rx_ready`=1 → `rx_valid` pulses for 1 cycle, `rx_data`=0xA5, no error flags.
- Low glitch of 5 `clk` on an idle line → return to IDLE, `busy` high for at most 9 cycles, no flags, `rx_valid` stays 0.
- Frame 0x3C with stop bit driven 0 → `frame_err` pulses once, `rx_valid` stays 0, `rx_data` unchanged.
- Two frames 0x11 then 0x22 with `rx_ready`=0 → `overrun_err` pulses on the second load, `rx_data`=0x22, `rx_valid`=1.
- Assert `rst` at data bit 4 of 0xFF, then send 0x5A → only 0x5A delivered, no flags.
- With `UART_RX_PARITY_EN`: 0x07 sent with parity bit 0 → `rx_data`=0x07, `parity_err` pulses; same byte with parity bit 1 → no error.
